// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address
// and latches the returned word into the IF/ID pipeline register.
// A start/done run-state machine brackets one pass through memory, which ends
// after the last word before the PC wraps.
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating fetch and stall
// counters as extra output ports.
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic [31:0]           imem_instruction,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           ifid_instruction,
    output logic [ADDR_WIDTH-1:0] ifid_pc_plus4,
    output logic                  ifid_valid,
    output logic                  done
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]           fetch_count,
    output logic [31:0]           stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] LAST_PC    = ALIGN_MASK;
    localparam logic [31:0]           NOP        = 32'h0;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [31:0]             ifid_instruction_q, ifid_instruction_d;
    logic [ADDR_WIDTH-1:0]   ifid_pc_plus4_q, ifid_pc_plus4_d;
    logic                    ifid_valid_q, ifid_valid_d;
    logic [ADDR_WIDTH-1:0]   pc_plus4;

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0]             fetch_count_q, fetch_count_d;
    logic [31:0]             stall_count_q, stall_count_d;
`endif

    assign pc_plus4         = pc_q + PC_STEP;
    assign imem_address     = pc_q;
    assign pc               = pc_q;
    assign ifid_instruction = ifid_instruction_q;
    assign ifid_pc_plus4    = ifid_pc_plus4_q;
    assign ifid_valid       = ifid_valid_q;
    assign done             = (state_q == DONE);

`ifdef FETCH_PERF_COUNTERS_EN
    assign fetch_count      = fetch_count_q;
    assign stall_count      = stall_count_q;
`endif

    // Next-state logic: branch beats stall beats sequential fetch while running.
    always_comb begin
        state_d            = state_q;
        pc_d               = pc_q;
        ifid_instruction_d = ifid_instruction_q;
        ifid_pc_plus4_d    = ifid_pc_plus4_q;
        ifid_valid_d       = ifid_valid_q;
`ifdef FETCH_PERF_COUNTERS_EN
        fetch_count_d      = fetch_count_q;
        stall_count_d      = stall_count_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (branch_taken) begin
                    pc_d               = branch_target & ALIGN_MASK;
                    ifid_instruction_d = NOP;
                    ifid_valid_d       = 1'b0;
                end else if (stall) begin
`ifdef FETCH_PERF_COUNTERS_EN
                    if (stall_count_q != 32'hFFFF_FFFF) begin
                        stall_count_d = stall_count_q + 32'd1;
                    end
`endif
                end else begin
                    ifid_instruction_d = imem_instruction;
                    ifid_pc_plus4_d    = pc_plus4;
                    ifid_valid_d       = 1'b1;
                    pc_d               = pc_plus4;
                    if (pc_q == LAST_PC) begin
                        state_d = DONE;
                    end
`ifdef FETCH_PERF_COUNTERS_EN
                    if (fetch_count_q != 32'hFFFF_FFFF) begin
                        fetch_count_d = fetch_count_q + 32'd1;
                    end
`endif
                end
            end

            DONE: begin
                ifid_instruction_d = NOP;
                ifid_valid_d       = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            pc_q               <= RESET_PC;
            ifid_instruction_q <= NOP;
            ifid_pc_plus4_q    <= '0;
            ifid_valid_q       <= 1'b0;
`ifdef FETCH_PERF_COUNTERS_EN
            fetch_count_q      <= 32'd0;
            stall_count_q      <= 32'd0;
`endif
        end else begin
            state_q            <= state_d;
            pc_q               <= pc_d;
            ifid_instruction_q <= ifid_instruction_d;
            ifid_pc_plus4_q    <= ifid_pc_plus4_d;
            ifid_valid_q       <= ifid_valid_d;
`ifdef FETCH_PERF_COUNTERS_EN
            fetch_count_q      <= fetch_count_d;
            stall_count_q      <= stall_count_d;
`endif
        end
    end

endmodule
